// File: rtl/reg_wb_sched.sv
// Writeback scheduler and pending-write scoreboard for the 8x16 register file.
// Define WB_FIXED_PRIO_EN for fixed MEM-over-ALU priority instead of round-robin.
module reg_wb_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [2:0]  issue_dest,
  output logic        issue_ready,
  input  logic [2:0]  rd_a,
  input  logic [2:0]  rd_b,
  output logic        hazard,
  input  logic        alu_valid,
  input  logic [2:0]  alu_dest,
  input  logic [15:0] alu_data,
  input  logic        alu_hb,
  input  logic        alu_lb,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_dest,
  input  logic [15:0] mem_data,
  input  logic        mem_hb,
  input  logic        mem_lb,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [2:0]  rf_dest,
  output logic [15:0] rf_data,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic [7:0]  busy,
  output logic        wb_err
);
  logic [7:0]  busy_q, busy_d;
  logic        wb_err_q, wb_err_d;
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_dest_q, rf_dest_d;
  logic [15:0] rf_data_q, rf_data_d;
  logic        rf_hb_q, rf_hb_d, rf_lb_q, rf_lb_d;
  logic        alu_gnt, mem_gnt;

  assign issue_ready = !busy_q[issue_dest];
  assign hazard      = busy_q[rd_a] | busy_q[rd_b];

`ifdef WB_FIXED_PRIO_EN
  assign alu_gnt = alu_valid & !mem_valid;
`else
  typedef enum logic {LAST_ALU = 1'b0, LAST_MEM = 1'b1} last_e;
  last_e last_q;

  // Tie goes to whoever was not granted most recently.
  assign alu_gnt = alu_valid & (!mem_valid | (last_q == LAST_MEM));

  always_ff @(posedge clk) begin
    if (rst)          last_q <= LAST_MEM;
    else if (alu_gnt) last_q <= LAST_ALU;
    else if (mem_gnt) last_q <= LAST_MEM;
  end
`endif
  assign mem_gnt   = mem_valid & !alu_gnt;
  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_comb begin
    busy_d    = busy_q;
    wb_err_d  = wb_err_q;
    rf_we_d   = alu_gnt | mem_gnt;
    rf_dest_d = rf_dest_q;
    rf_data_d = rf_data_q;
    rf_hb_d   = rf_hb_q;
    rf_lb_d   = rf_lb_q;
    // Clear lands on the same edge the register file commits the data.
    if (rf_we_q) begin
      if (!busy_q[rf_dest_q]) wb_err_d = 1'b1;
      busy_d[rf_dest_q] = 1'b0;
    end
    if (issue_valid && issue_ready) busy_d[issue_dest] = 1'b1;
    if (alu_gnt) begin
      rf_dest_d = alu_dest;
      rf_data_d = alu_data;
      rf_hb_d   = alu_hb;
      rf_lb_d   = alu_lb;
    end else if (mem_gnt) begin
      rf_dest_d = mem_dest;
      rf_data_d = mem_data;
      rf_hb_d   = mem_hb;
      rf_lb_d   = mem_lb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      wb_err_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
      rf_hb_q   <= 1'b0;
      rf_lb_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wb_err_q  <= wb_err_d;
      rf_we_q   <= rf_we_d;
      rf_dest_q <= rf_dest_d;
      rf_data_q <= rf_data_d;
      rf_hb_q   <= rf_hb_d;
      rf_lb_q   <= rf_lb_d;
    end
  end

  assign busy    = busy_q;
  assign wb_err  = wb_err_q;
  assign rf_we   = rf_we_q;
  assign rf_dest = rf_dest_q;
  assign rf_data = rf_data_q;
  assign rf_hb   = rf_hb_q;
  assign rf_lb   = rf_lb_q;
endmodule
